uart_rx_fifo: RTL and testbench

- Receive buffer that sits directly downstream of uart_rx.
- Captures each byte presented on rx_dout when rx_done_tick pulses.
- Stores bytes in a circular FIFO until the host/consumer logic pops them.
- Decouples the bursty byte-rate UART receiver from the slower or irregular consumer, and flags lost bytes (overrun).

---
 rtl/uart_rx_fifo_if.sv | 43 ++++
 rtl/uart_rx_fifo.sv | 108 ++++++++++
 tb/tb_uart_rx_fifo.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Byte-capture, pop and status signals of uart_rx_fifo.
// rx_thresh is present only when UART_RX_FIFO_THRESH_EN is defined.
interface uart_rx_fifo_if #(
  parameter int DBIT   = 8,
  parameter int ADDR_W = 4
);
  // rx_done_tick is a one-cycle push strobe with no backpressure: a byte
  // offered while full (and not popped in the same cycle) is dropped.
  // rd_en pops the head at a rising edge only when empty=0; rd_data shows
  // the head with no read latency and reads 0 while empty.
  logic              rx_done_tick;
  logic [DBIT-1:0]   rx_dout;
  logic              rd_en;
  logic              clr_overrun;
  logic [DBIT-1:0]   rd_data;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   level;
  logic              overrun;
`ifdef UART_RX_FIFO_THRESH_EN
  logic              rx_thresh;

  modport master (
    output rx_done_tick, rx_dout, rd_en, clr_overrun,
    input  rd_data, empty, full, level, overrun, rx_thresh
  );

  modport slave (
    input  rx_done_tick, rx_dout, rd_en, clr_overrun,
    output rd_data, empty, full, level, overrun, rx_thresh
  );
`else
  modport master (
    output rx_done_tick, rx_dout, rd_en, clr_overrun,
    input  rd_data, empty, full, level, overrun
  );

  modport slave (
    input  rx_done_tick, rx_dout, rd_en, clr_overrun,
    output rd_data, empty, full, level, overrun
  );
`endif
endinterface

// File: rtl/uart_rx_fifo.sv
// Circular receive FIFO behind uart_rx with first-word-fall-through and sticky overrun.
// Optional level-threshold output enabled by defining UART_RX_FIFO_THRESH_EN.
module uart_rx_fifo #(
  parameter int DBIT   = 8,
  parameter int ADDR_W = 4
`ifdef UART_RX_FIFO_THRESH_EN
  ,
  parameter int THRESH = 12
`endif
) (
  input  logic          clk_i,
  input  logic          reset_i,
  uart_rx_fifo_if.slave bus
);

  localparam int              DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LVL_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [DBIT-1:0]   mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              overrun_q, overrun_d;

  logic              do_wr;
  logic              do_rd;
  logic              drop;

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a
  // byte when rd_en arrives alongside it.
  assign do_rd = bus.rd_en & ~empty_q;
  assign do_wr = bus.rx_done_tick & (~full_q | do_rd);
  assign drop  = bus.rx_done_tick & full_q & ~do_rd;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    overrun_d = overrun_q;

    if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;

    case ({do_wr, do_rd})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    empty_d = (level_d == '0);
    full_d  = (level_d == FULL_LVL);

    // A drop at the same edge as a clear leaves overrun set.
    if (bus.clr_overrun) overrun_d = 1'b0;
    if (drop)            overrun_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage is deliberately left unreset; empty_q masks stale contents.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem[wr_ptr_q] <= bus.rx_dout;
  end

  assign bus.rd_data = empty_q ? '0 : mem[rd_ptr_q];
  assign bus.empty   = empty_q;
  assign bus.full    = full_q;
  assign bus.level   = level_q;
  assign bus.overrun = overrun_q;

`ifdef UART_RX_FIFO_THRESH_EN
  localparam logic [ADDR_W:0] THRESH_LVL = (ADDR_W + 1)'(THRESH);

  logic rx_thresh_q, rx_thresh_d;

  // Compared on next-state level so the flag rises on the edge level reaches THRESH.
  assign rx_thresh_d = (level_d >= THRESH_LVL);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) rx_thresh_q <= 1'b0;
    else         rx_thresh_q <= rx_thresh_d;
  end

  assign bus.rx_thresh = rx_thresh_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and randomized checks of uart_rx_fifo against a queue-based FIFO model.
module tb_uart_rx_fifo;

  localparam int DBIT   = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int THRESH = 12;

  logic clk;
  logic reset;

  int checks   = 0;
  int failures = 0;

  // Reference model: contents in arrival order plus the sticky drop flag.
  logic [DBIT-1:0] exp_q[$];
  logic            ovf_m = 1'b0;

  uart_rx_fifo_if #(.DBIT(DBIT), .ADDR_W(ADDR_W)) bus ();

  uart_rx_fifo dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = exp_q.size();
    check({tag, ".level"},   32'(bus.level),   32'(n));
    check({tag, ".empty"},   32'(bus.empty),   32'(n == 0));
    check({tag, ".full"},    32'(bus.full),    32'(n == DEPTH));
    check({tag, ".overrun"}, 32'(bus.overrun), 32'(ovf_m));
    check({tag, ".rd_data"}, 32'(bus.rd_data), (n > 0) ? 32'(exp_q[0]) : 32'h0);
`ifdef UART_RX_FIFO_THRESH_EN
    check({tag, ".rx_thresh"}, 32'(bus.rx_thresh), 32'(n >= THRESH));
`endif
  endtask

  task automatic model_edge(input logic wr, input logic [DBIT-1:0] d,
                            input logic rd, input logic clr);
    if (clr) ovf_m = 1'b0;
    if (rd && exp_q.size() > 0) void'(exp_q.pop_front());
    if (wr) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
      else ovf_m = 1'b1;
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input string tag, input logic wr, input logic [DBIT-1:0] d,
                      input logic rd, input logic clr);
    bus.rx_done_tick = wr;
    bus.rx_dout      = d;
    bus.rd_en        = rd;
    bus.clr_overrun  = clr;
    @(posedge clk);
    #1;
    model_edge(wr, d, rd, clr);
    bus.rx_done_tick = 1'b0;
    bus.rd_en        = 1'b0;
    bus.clr_overrun  = 1'b0;
    check_all(tag);
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) step(tag, 1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic fill_random(input string tag);
    while (exp_q.size() < DEPTH) step(tag, 1'b1, DBIT'($urandom), 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset            = 1'b1;
    bus.rx_done_tick = 1'b0;
    bus.rx_dout      = '0;
    bus.rd_en        = 1'b0;
    bus.clr_overrun  = 1'b0;

    // Reset then idle
    repeat (10) @(posedge clk);
    #1;
    check_all("reset_held");
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_all("reset_idle");
    check("reset_idle.rd_data_zero", 32'(bus.rd_data), 32'h0);

    // Single byte in and out
    step("single_wr", 1'b1, 8'hA5, 1'b0, 1'b0);
    check("single_wr.data_A5", 32'(bus.rd_data), 32'hA5);
    check("single_wr.level_1", 32'(bus.level), 32'd1);
    step("single_rd", 1'b0, '0, 1'b1, 1'b0);
    check("single_rd.empty", 32'(bus.empty), 32'd1);

    // Pop while empty is ignored
    step("pop_empty", 1'b0, '0, 1'b1, 1'b0);

    // Fill and ordered drain, twice (pointers start at 1, so both passes wrap)
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < DEPTH; i++)
        step("fill", 1'b1, DBIT'(pass * 16 + i), 1'b0, 1'b0);
      check("fill.full", 32'(bus.full), 32'd1);
      check("fill.level_16", 32'(bus.level), 32'd16);
      for (int i = 0; i < DEPTH; i++) begin
        check("order.head", 32'(bus.rd_data), 32'(pass * 16 + i));
        step("order", 1'b0, '0, 1'b1, 1'b0);
      end
      check("order.empty", 32'(bus.empty), 32'd1);
    end

    // Overrun: drop, clear, clear-vs-drop collision
    fill_random("ovr_fill");
    step("ovr_drop", 1'b1, 8'hFF, 1'b0, 1'b0);
    check("ovr_drop.overrun_1", 32'(bus.overrun), 32'd1);
    check("ovr_drop.level_16", 32'(bus.level), 32'd16);
    step("ovr_clr", 1'b0, '0, 1'b0, 1'b1);
    check("ovr_clr.overrun_0", 32'(bus.overrun), 32'd0);
    step("ovr_clr_and_drop", 1'b1, 8'hEE, 1'b0, 1'b1);
    check("ovr_clr_and_drop.set_wins", 32'(bus.overrun), 32'd1);
    step("ovr_clr2", 1'b0, '0, 1'b0, 1'b1);
    drain("ovr_drain");

    // Full with write and read at the same edge
    fill_random("sim_full_fill");
    step("sim_full", 1'b1, 8'h77, 1'b1, 1'b0);
    check("sim_full.level_16", 32'(bus.level), 32'd16);
    check("sim_full.overrun_0", 32'(bus.overrun), 32'd0);
    while (exp_q.size() > 1) step("sim_full_drain", 1'b0, '0, 1'b1, 1'b0);
    check("sim_full.last_77", 32'(bus.rd_data), 32'h77);
    step("sim_full_last", 1'b0, '0, 1'b1, 1'b0);

    // Empty with write and read at the same edge
    step("sim_empty", 1'b1, 8'h3C, 1'b1, 1'b0);
    check("sim_empty.level_1", 32'(bus.level), 32'd1);
    check("sim_empty.data_3C", 32'(bus.rd_data), 32'h3C);
    step("sim_empty_pop", 1'b0, '0, 1'b1, 1'b0);

    // Threshold crossing
    for (int i = 0; i < THRESH - 1; i++)
      step("thr_below", 1'b1, DBIT'($urandom), 1'b0, 1'b0);
    step("thr_reach", 1'b1, DBIT'($urandom), 1'b0, 1'b0);
    step("thr_pop", 1'b0, '0, 1'b1, 1'b0);
    drain("thr_drain");

    // Reset mid-stream with a byte in flight
    fill_random("rst_fill");
    step("rst_drop", 1'b1, 8'hFF, 1'b0, 1'b0);
    bus.rx_done_tick = 1'b1;
    bus.rx_dout      = 8'h5A;
    #2;
    reset = 1'b1;
    #1;
    exp_q.delete();
    ovf_m = 1'b0;
    check_all("rst_async");
    @(posedge clk);
    #1;
    check_all("rst_inflight");
    bus.rx_done_tick = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_all("rst_release");

    // Randomized traffic: filling phase, then draining phase
    for (int i = 0; i < 600; i++) begin
      logic wr, rd, clr;
      if (i < 300) begin
        wr = ($urandom_range(0, 3) != 0);
        rd = ($urandom_range(0, 3) == 0);
      end else begin
        wr = ($urandom_range(0, 3) == 0);
        rd = ($urandom_range(0, 3) != 0);
      end
      clr = ($urandom_range(0, 15) == 0);
      step("rand", wr, DBIT'($urandom), rd, clr);
    end
    drain("rand_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
